// File: rtl/xrv_pkg.sv
// -----------------------------------------------------------------------------
// xrv_pkg
// Shared types and constants for the xrv data-bus bridge and its helpers.
//   dbus_state_t  : bridge FSM states (IDLE, SRAM, PREQ, RESP)
//   DBUS_ERR_DATA : read data returned when a peripheral access times out
// -----------------------------------------------------------------------------
package xrv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRAM = 2'd1,
    PREQ = 2'd2,
    RESP = 2'd3
  } dbus_state_t;

  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/xrv_dbus_bridge_if.sv
// -----------------------------------------------------------------------------
// xrv_dbus_bridge_if
// Groups the three buses around the data-bus bridge:
//   d_* : core load/store port (core drives requests, bridge returns ready)
//   m_* : tightly-coupled SRAM (fixed 1-cycle read latency)
//   p_* : peripheral port
// Modports:
//   slave  : the bridge's view (core requests in, SRAM/peripheral requests out)
//   master : the surrounding system's view (core, SRAM and peripheral models)
//
// Handshake semantics:
//   Core side   : d_wr_req/d_rd_req are held until the matching one-cycle
//                 d_wr_ready/d_rd_ready pulse; the core drops (or changes) the
//                 request the cycle after the pulse. Write wins if both are set.
//   Peripheral  : p_valid rises with a stable p_addr/p_be/p_wdata/p_write and
//                 stays high until the first cycle with p_ready=1 (transfer
//                 completes in that cycle, p_rdata sampled there) or until the
//                 bridge gives up on timeout. p_valid may also drop on reset,
//                 abandoning the request.
// -----------------------------------------------------------------------------
interface xrv_dbus_bridge_if #(
  parameter int SRAM_AW = 12
);
  logic [31:0]        d_addr;
  logic               d_wr_req;
  logic               d_rd_req;
  logic [3:0]         d_be;
  logic [31:0]        d_wr_data;
  logic               d_wr_ready;
  logic               d_rd_ready;
  logic [31:0]        d_rd_data;

  logic               m_cs;
  logic               m_we;
  logic [3:0]         m_be;
  logic [SRAM_AW-1:0] m_addr;
  logic [31:0]        m_wdata;
  logic [31:0]        m_rdata;

  logic               p_valid;
  logic               p_write;
  logic [31:0]        p_addr;
  logic [3:0]         p_be;
  logic [31:0]        p_wdata;
  logic               p_ready;
  logic [31:0]        p_rdata;

  modport slave (
    input  d_addr, d_wr_req, d_rd_req, d_be, d_wr_data,
    output d_wr_ready, d_rd_ready, d_rd_data,
    output m_cs, m_we, m_be, m_addr, m_wdata,
    input  m_rdata,
    output p_valid, p_write, p_addr, p_be, p_wdata,
    input  p_ready, p_rdata
  );

  modport master (
    output d_addr, d_wr_req, d_rd_req, d_be, d_wr_data,
    input  d_wr_ready, d_rd_ready, d_rd_data,
    input  m_cs, m_we, m_be, m_addr, m_wdata,
    output m_rdata,
    input  p_valid, p_write, p_addr, p_be, p_wdata,
    output p_ready, p_rdata
  );

endinterface

// File: rtl/xrv_bus_timer.sv
// -----------------------------------------------------------------------------
// xrv_bus_timer
// 16-bit saturating wait counter with a timeout compare. Shared by the data
// and instruction bus bridges.
//   clk, rstb : clock, synchronous active-low reset
//   clr       : restart counting from zero (takes priority over en)
//   en        : count this cycle
//   expired   : the current waiting cycle is the TIMEOUT-th one since clr
// -----------------------------------------------------------------------------
module xrv_bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count is zero during the first waiting cycle, so the TIMEOUT-th
  // waiting cycle sees count == TIMEOUT-1.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/xrv_dbus_bridge.sv
// -----------------------------------------------------------------------------
// xrv_dbus_bridge
// Routes core load/store requests to the tightly-coupled SRAM or to the
// peripheral port, returning a one-cycle ready pulse to the core.
//   clk, rstb : clock, synchronous active-low reset
//   bus       : d_* core port, m_* SRAM port, p_* peripheral port
//   bus_err   : sticky peripheral-timeout flag, cleared only by reset
//   state_dbg : current FSM state
// -----------------------------------------------------------------------------
module xrv_dbus_bridge
  import xrv_pkg::*;
#(
  parameter int SRAM_AW    = 12,
  parameter int PERIPH_BIT = 31,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rstb,
  xrv_dbus_bridge_if.slave    bus,
  output logic                bus_err,
  output dbus_state_t         state_dbg
);

  dbus_state_t state_q, state_d;

  logic               is_wr_q;
  logic [31:0]        rdata_q;
  logic               p_valid_q, p_write_q;
  logic [31:0]        p_addr_q, p_wdata_q;
  logic [3:0]         p_be_q;
  logic               bus_err_q;

  logic               accept_s, accept_p, p_done, p_tmo, expired;
  logic               m_cs, m_we, wr_ready, rd_ready;
  logic [3:0]         m_be;
  logic [SRAM_AW-1:0] m_addr;
  logic [31:0]        m_wdata, rd_data;

  wire any_req   = bus.d_wr_req | bus.d_rd_req;
  wire is_periph = bus.d_addr[PERIPH_BIT];

  xrv_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (accept_p),
    .en      ((state_q == PREQ) && !bus.p_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    accept_p = 1'b0;
    p_done   = 1'b0;
    p_tmo    = 1'b0;
    m_cs     = 1'b0;
    m_we     = 1'b0;
    m_be     = 4'd0;
    m_addr   = '0;
    m_wdata  = 32'd0;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    rd_data  = rdata_q;
    case (state_q)
      IDLE: begin
        // Gated by rstb so no SRAM strobe escapes while reset is held.
        if (rstb && any_req) begin
          if (!is_periph) begin
            accept_s = 1'b1;
            m_cs     = 1'b1;
            m_we     = bus.d_wr_req;
            m_be     = bus.d_be;
            m_addr   = bus.d_addr[SRAM_AW+1:2];
            m_wdata  = bus.d_wr_data;
            state_d  = SRAM;
          end else begin
            accept_p = 1'b1;
            state_d  = PREQ;
          end
        end
      end
      SRAM: begin
        wr_ready = is_wr_q;
        rd_ready = !is_wr_q;
        rd_data  = bus.m_rdata;
        state_d  = IDLE;
      end
      PREQ: begin
        // A ready arriving in the expiry cycle still counts as a success.
        if (bus.p_ready) begin
          p_done  = 1'b1;
          state_d = RESP;
        end else if (expired) begin
          p_tmo   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        wr_ready = is_wr_q;
        rd_ready = !is_wr_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      is_wr_q   <= 1'b0;
      rdata_q   <= 32'd0;
      p_valid_q <= 1'b0;
      p_write_q <= 1'b0;
      p_addr_q  <= 32'd0;
      p_be_q    <= 4'd0;
      p_wdata_q <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      if (accept_s || accept_p) is_wr_q <= bus.d_wr_req;
      if (accept_p) begin
        p_valid_q <= 1'b1;
        p_write_q <= bus.d_wr_req;
        p_addr_q  <= bus.d_addr;
        p_be_q    <= bus.d_be;
        p_wdata_q <= bus.d_wr_data;
      end
      if (p_done) begin
        p_valid_q <= 1'b0;
        rdata_q   <= bus.p_rdata;
      end
      if (p_tmo) begin
        p_valid_q <= 1'b0;
        rdata_q   <= DBUS_ERR_DATA;
        bus_err_q <= 1'b1;
      end
    end
  end

  assign bus.m_cs       = m_cs;
  assign bus.m_we       = m_we;
  assign bus.m_be       = m_be;
  assign bus.m_addr     = m_addr;
  assign bus.m_wdata    = m_wdata;
  assign bus.d_wr_ready = wr_ready;
  assign bus.d_rd_ready = rd_ready;
  assign bus.d_rd_data  = rd_data;
  assign bus.p_valid    = p_valid_q;
  assign bus.p_write    = p_write_q;
  assign bus.p_addr     = p_addr_q;
  assign bus.p_be       = p_be_q;
  assign bus.p_wdata    = p_wdata_q;
  assign bus_err        = bus_err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_xrv_dbus_bridge.sv
// -----------------------------------------------------------------------------
// tb_xrv_dbus_bridge
// Directed bench for xrv_dbus_bridge. Transaction tasks derive, from the
// bridge's latency rules, what every output must be in each cycle and queue
// that expectation; one compare process checks the DUT every cycle. A monitor
// records a few observed values that are pinned against literals.
// -----------------------------------------------------------------------------
module tb_xrv_dbus_bridge;
  import xrv_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        bus_err;
  dbus_state_t state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  xrv_dbus_bridge_if #(.SRAM_AW(12)) bus ();

  xrv_dbus_bridge #(.SRAM_AW(12), .PERIPH_BIT(31), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .bus_err   (bus_err),
    .state_dbg (state_dbg)
  );

  typedef struct packed {
    logic        rstb;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        pready;
    logic [31:0] prdata;
  } drv_t;

  typedef struct packed {
    logic        m_cs;
    logic        m_we;
    logic [11:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        p_valid;
    logic        p_write;
    logic [31:0] p_addr;
    logic [3:0]  p_be;
    logic [31:0] p_wdata;
    logic        wr_ready;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        bus_err;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            total = 0;
  int            bad   = 0;

  // Model state: last value latched for the core from the peripheral side,
  // and the sticky error flag.
  logic [31:0] model_rdq = 32'd0;
  logic        model_err = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endfunction

  initial begin : compare
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".m_cs"},     32'(bus.m_cs),       32'(e.m_cs));
        if (e.m_cs) begin
          chk({t, ".m_we"},    32'(bus.m_we),    32'(e.m_we));
          chk({t, ".m_addr"},  32'(bus.m_addr),  32'(e.m_addr));
          chk({t, ".m_be"},    32'(bus.m_be),    32'(e.m_be));
          chk({t, ".m_wdata"}, bus.m_wdata,      e.m_wdata);
        end
        chk({t, ".p_valid"},  32'(bus.p_valid),    32'(e.p_valid));
        if (e.p_valid) begin
          chk({t, ".p_write"}, 32'(bus.p_write), 32'(e.p_write));
          chk({t, ".p_addr"},  bus.p_addr,       e.p_addr);
          chk({t, ".p_be"},    32'(bus.p_be),    32'(e.p_be));
          chk({t, ".p_wdata"}, bus.p_wdata,      e.p_wdata);
        end
        chk({t, ".wr_ready"}, 32'(bus.d_wr_ready), 32'(e.wr_ready));
        chk({t, ".rd_ready"}, 32'(bus.d_rd_ready), 32'(e.rd_ready));
        chk({t, ".rd_data"},  bus.d_rd_data,       e.rd_data);
        chk({t, ".bus_err"},  32'(bus_err),        32'(e.bus_err));
      end
    end
  end

  // Observed values used by the literal checks.
  logic [11:0] last_m_addr = '0;
  logic [3:0]  last_m_be   = '0;
  logic [31:0] last_rd     = '0;
  int          pv_run      = 0;
  int          pv_last     = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.m_cs) begin
        last_m_addr = bus.m_addr;
        last_m_be   = bus.m_be;
      end
      if (bus.d_rd_ready) last_rd = bus.d_rd_data;
      if (bus.p_valid) pv_run++;
      else if (pv_run > 0) begin
        pv_last = pv_run;
        pv_run  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic drv_t idle_drv();
    drv_t d;
    d      = '0;
    d.rstb = 1'b1;
    return d;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e         = '0;
    e.rd_data = model_rdq;
    e.bus_err = model_err;
    return e;
  endfunction

  task automatic step(input drv_t d, input exp_t e, input string tag, input bit check);
    @(posedge clk);
    #1;
    rstb          = d.rstb;
    bus.d_wr_req  = d.wr;
    bus.d_rd_req  = d.rd;
    bus.d_addr    = d.addr;
    bus.d_be      = d.be;
    bus.d_wr_data = d.wdata;
    bus.m_rdata   = d.mrdata;
    bus.p_ready   = d.pready;
    bus.p_rdata   = d.prdata;
    if (check) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  // SRAM access: strobe in the request cycle, ready the next cycle with
  // read data passed straight through from the SRAM.
  task automatic sram_txn(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] mrd, input string tag);
    drv_t d;
    exp_t e;
    d       = idle_drv();
    d.wr    = wr;
    d.rd    = rd;
    d.addr  = addr;
    d.be    = be;
    d.wdata = wdata;
    e           = idle_exp();
    e.m_cs      = 1'b1;
    e.m_we      = wr;
    e.m_addr    = addr[13:2];
    e.m_be      = be;
    e.m_wdata   = wdata;
    step(d, e, {tag, ".req"}, 1'b1);
    d.mrdata   = mrd;
    e          = idle_exp();
    e.wr_ready = wr;
    e.rd_ready = !wr;
    e.rd_data  = mrd;
    step(d, e, {tag, ".rdy"}, 1'b1);
  endtask

  // Peripheral access: p_ready arrives after `waits` waiting cycles. p_valid
  // lasts min(waits+1, TMO) cycles; a ready in the last allowed cycle wins.
  task automatic periph_txn(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] prd, input string tag);
    drv_t d;
    exp_t e;
    int   nvalid;
    bit   ok;
    ok     = (waits < TMO);
    nvalid = ok ? waits + 1 : TMO;
    d       = idle_drv();
    d.wr    = wr;
    d.rd    = !wr;
    d.addr  = addr;
    d.be    = be;
    d.wdata = wdata;
    step(d, idle_exp(), {tag, ".req"}, 1'b1);
    for (int i = 0; i < nvalid; i++) begin
      d.pready  = (i == waits);
      d.prdata  = (i == waits) ? prd : 32'h0;
      e         = idle_exp();
      e.p_valid = 1'b1;
      e.p_write = wr;
      e.p_addr  = addr;
      e.p_be    = be;
      e.p_wdata = wdata;
      step(d, e, {tag, ".pv"}, 1'b1);
    end
    model_rdq  = ok ? prd : 32'hDEAD_BEEF;
    model_err  = model_err | !ok;
    d.pready   = 1'b0;
    d.prdata   = 32'h0;
    e          = idle_exp();
    e.wr_ready = wr;
    e.rd_ready = !wr;
    step(d, e, {tag, ".rdy"}, 1'b1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] tbl_addr[3] = '{32'h0000_0ffc, 32'h0000_3000, 32'h7fff_c004};
  logic [31:0] tbl_data[3] = '{32'h0102_0304, 32'hffff_0000, 32'h8000_0001};
  logic [3:0]  tbl_be[3]   = '{4'b1111, 4'b1000, 4'b0101};

  initial begin : main
    drv_t d;
    exp_t e;
    bus.d_wr_req  = 1'b0;
    bus.d_rd_req  = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_be      = 4'h0;
    bus.d_wr_data = 32'h0;
    bus.m_rdata   = 32'h0;
    bus.p_ready   = 1'b0;
    bus.p_rdata   = 32'h0;

    d      = idle_drv();
    d.rstb = 1'b0;
    step(d, idle_exp(), "rst0", 1'b0);
    step(d, idle_exp(), "rst1", 1'b1);
    settle();
    chk("reset_state", 32'(state_dbg), 32'(IDLE));

    sram_txn(1'b1, 1'b0, 32'h40, 4'b0011, 32'h1234_5678, 32'h1111_2222, "sram_wr");
    settle();
    chk("lit_m_addr", 32'(last_m_addr), 32'h010);
    chk("lit_m_be",   32'(last_m_be),   32'h3);

    sram_txn(1'b0, 1'b1, 32'h40, 4'b1111, 32'h0, 32'hCAFE_F00D, "sram_rd");
    settle();
    chk("lit_sram_rd", last_rd, 32'hCAFE_F00D);
    sram_txn(1'b0, 1'b1, 32'h40, 4'b1111, 32'h0, 32'h0BAD_F00D, "sram_rd2");

    sram_txn(1'b1, 1'b1, 32'h80, 4'b1111, 32'hA1B2_C3D4, 32'h5555_5555, "both");

    for (int i = 0; i < 3; i++)
      sram_txn(i[0], !i[0], tbl_addr[i], tbl_be[i], tbl_data[i], ~tbl_data[i], "sram_tbl");

    periph_txn(1'b0, 32'h8000_0010, 4'b1111, 32'h0, 5, 32'hA5A5_0001, "p_rd");
    settle();
    chk("lit_pv_len6", pv_last, 6);
    chk("lit_p_rd",    last_rd, 32'hA5A5_0001);

    periph_txn(1'b1, 32'h8000_0104, 4'b1100, 32'h7777_8888, TMO - 1, 32'h0, "p_race");
    settle();
    chk("lit_race_err", 32'(bus_err), 32'h0);

    periph_txn(1'b1, 32'h8000_0200, 4'b0001, 32'h0000_00AB, 1000, 32'h0, "p_tmo");
    settle();
    chk("lit_pv_len8", pv_last, TMO);
    chk("lit_tmo_err", 32'(bus_err), 32'h1);

    periph_txn(1'b0, 32'hC000_0008, 4'b1111, 32'h0, 0, 32'h1357_9BDF, "p_fast");
    sram_txn(1'b1, 1'b0, 32'h100, 4'b1111, 32'hFEED_0001, 32'h0, "sram_after");
    settle();
    chk("lit_err_sticky", 32'(bus_err), 32'h1);

    // Reset while a peripheral request is outstanding.
    d      = idle_drv();
    d.rd   = 1'b1;
    d.addr = 32'h8000_0020;
    d.be   = 4'b1111;
    step(d, idle_exp(), "rst_mid.req", 1'b1);
    e         = idle_exp();
    e.p_valid = 1'b1;
    e.p_write = 1'b0;
    e.p_addr  = 32'h8000_0020;
    e.p_be    = 4'b1111;
    e.p_wdata = 32'h0;
    step(d, e, "rst_mid.pv", 1'b1);
    d.rstb = 1'b0;
    step(d, e, "rst_mid.rst", 1'b1);
    model_rdq = 32'd0;
    model_err = 1'b0;
    step(idle_drv(), idle_exp(), "rst_mid.after", 1'b1);
    settle();
    chk("rst_mid_state", 32'(state_dbg), 32'(IDLE));

    sram_txn(1'b0, 1'b1, 32'h100, 4'b1111, 32'h0, 32'h2468_ACE0, "sram_post_rst");
    step(idle_drv(), idle_exp(), "tail", 1'b1);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
